// File: rtl/core8_mem_arbiter_if.sv
// Avalon-MM master-side bundle for one core of the pair sharing the RAM.
// Optional lock line present when CORE8_MEM_ARB_LOCK_EN is defined.
interface core8_mem_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
`ifdef CORE8_MEM_ARB_LOCK_EN
  logic                lock;

  modport master (
    output address, byteenable, read, write, writedata, lock,
    input  waitrequest, readdata, readdatavalid
  );
  modport slave (
    input  address, byteenable, read, write, writedata, lock,
    output waitrequest, readdata, readdatavalid
  );
`else
  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );
  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
`endif
endinterface

// File: rtl/core8_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port 8192x32 RAM.
// Winner's command is registered into a one-deep command stage; read data
// comes back two cycles after acceptance, tagged by a two-stage owner pipe.
// Optional bus lock for atomic mailbox access: CORE8_MEM_ARB_LOCK_EN.
//
// arbitration state | meaning
// last_grant = 0    | master 0 won last; master 1 wins a tie
// last_grant = 1    | master 1 won last; master 0 wins a tie
// locked = 1        | only locked_owner may be granted
module core8_mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  core8_mem_arbiter_if.slave  m0,
  core8_mem_arbiter_if.slave  m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);
  logic req0, req1, gnt0, gnt1, accept, win, win_write;
  logic last_grant;
  logic rp1_valid, rp1_owner, rp2_valid, rp2_owner;
`ifdef CORE8_MEM_ARB_LOCK_EN
  logic locked, locked_owner, win_lock;
`endif

  // Request decode and combinational grant; nothing is granted while in reset.
  always_comb begin
    req0 = m0.read | m0.write;
    req1 = m1.read | m1.write;
    gnt0 = reset_n & req0 & (~req1 | last_grant);
    gnt1 = reset_n & req1 & (~req0 | ~last_grant);
`ifdef CORE8_MEM_ARB_LOCK_EN
    if (locked) begin
      gnt0 = reset_n & req0 & ~locked_owner;
      gnt1 = reset_n & req1 & locked_owner;
    end
    win_lock = gnt1 ? m1.lock : m0.lock;
`endif
    accept    = gnt0 | gnt1;
    win       = gnt1;
    // read+write together is treated as a write
    win_write = gnt1 ? m1.write : m0.write;
  end

  assign m0.waitrequest   = ~gnt0;
  assign m1.waitrequest   = ~gnt1;
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;
  assign m0.readdatavalid = rp2_valid & ~rp2_owner;
  assign m1.readdatavalid = rp2_valid & rp2_owner;
  assign mem_clken        = 1'b1;

  // Command stage: load the winner's command, otherwise deselect the RAM.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant     <= 1'b1;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_writedata  <= '0;
    end else begin
      mem_chipselect <= accept;
      mem_write      <= accept & win_write;
      if (accept) begin
        last_grant     <= win;
        mem_address    <= win ? m1.address    : m0.address;
        mem_byteenable <= win ? m1.byteenable : m0.byteenable;
        mem_writedata  <= win ? m1.writedata  : m0.writedata;
      end
    end
  end

  // Read-return pipe: {valid, owner} shifts every cycle, lines up with RAM q.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rp1_valid <= 1'b0;
      rp1_owner <= 1'b0;
      rp2_valid <= 1'b0;
      rp2_owner <= 1'b0;
    end else begin
      rp1_valid <= accept & ~win_write;
      rp1_owner <= win;
      rp2_valid <= rp1_valid;
      rp2_owner <= rp1_owner;
    end
  end

`ifdef CORE8_MEM_ARB_LOCK_EN
  // Lock tracking: an accepted transfer sets or drops the lock by its lock bit
  // (while locked only the owner can be accepted); an idle owner with lock low
  // also releases it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      locked       <= 1'b0;
      locked_owner <= 1'b0;
    end else if (accept) begin
      locked <= win_lock;
      if (win_lock) locked_owner <= win;
    end else if (locked) begin
      if (locked_owner ? (~req1 & ~m1.lock) : (~req0 & ~m0.lock))
        locked <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_core8_mem_arbiter.sv
// Self-checking bench for core8_mem_arbiter: directed scenarios followed by
// random traffic, every cycle compared against a behavioural reference model
// (shadow memory plus a queue of expected read returns).
module tb_core8_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;

  core8_mem_arbiter_if #(.ADDR_W(13), .DATA_W(32)) m0_if ();
  core8_mem_arbiter_if #(.ADDR_W(13), .DATA_W(32)) m1_if ();

  core8_mem_arbiter #(.ADDR_W(13), .DATA_W(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .m0             (m0_if),
    .m1             (m1_if),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata)
  );

  always #5 clk = ~clk;

  // RAM behind the arbiter: registered address, unregistered q
  logic [31:0] ram [0:8191];
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  // Reference model state
  typedef struct {
    int          due;
    bit          owner;
    logic [31:0] data;
  } ret_t;

  logic [31:0] shadow [0:8191];
  ret_t        pend[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          m_last = 1'b1;
  bit          prev_acc = 1'b0;
  bit          prev_wr = 1'b0;
  bit          m_locked = 1'b0;
  bit          m_owner = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic drive(input int n, input bit rd, input bit wr, input logic [12:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    if (n == 0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
      m0_if.byteenable = be; m0_if.writedata = d;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
      m1_if.byteenable = be; m1_if.writedata = d;
    end
  endtask

`ifdef CORE8_MEM_ARB_LOCK_EN
  task automatic set_lock(input bit l0, input bit l1);
    m0_if.lock = l0;
    m1_if.lock = l1;
  endtask
`endif

  // One clock cycle: check outputs mid-cycle against the model, advance the
  // model, then return just after the next rising edge for new stimulus.
  task automatic step();
    bit r0, r1, g0, g1, w, wwr, e0, e1;
    logic [31:0] edat;
    logic [12:0] a;
`ifdef CORE8_MEM_ARB_LOCK_EN
    bit lk0, lk1;
`endif
    @(negedge clk);
    r0 = m0_if.read | m0_if.write;
    r1 = m1_if.read | m1_if.write;
    g0 = 1'b0; g1 = 1'b0;
    if (reset_n) begin
      if (r0 && r1) begin
        g0 = m_last;          // whoever did not win last time goes now
        g1 = !m_last;
      end else begin
        g0 = r0;
        g1 = r1;
      end
`ifdef CORE8_MEM_ARB_LOCK_EN
      if (m_locked) begin
        g0 = r0 && !m_owner;
        g1 = r1 && m_owner;
      end
`endif
    end
    chk("wait0", 32'(m0_if.waitrequest), 32'(!g0));
    chk("wait1", 32'(m1_if.waitrequest), 32'(!g1));

    e0 = 1'b0; e1 = 1'b0; edat = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      if (pend[0].owner) e1 = 1'b1; else e0 = 1'b1;
      edat = pend[0].data;
      void'(pend.pop_front());
    end
    chk("rdv0", 32'(m0_if.readdatavalid), 32'(e0));
    chk("rdv1", 32'(m1_if.readdatavalid), 32'(e1));
    if (e0) chk("rdata0", m0_if.readdata, edat);
    if (e1) chk("rdata1", m1_if.readdata, edat);
    chk("mem_cs", 32'(mem_chipselect), 32'(prev_acc));
    chk("mem_wr", 32'(mem_write), 32'(prev_wr));
    chk("mem_clken", 32'(mem_clken), 32'd1);

    if (!reset_n) begin
      m_last = 1'b1; pend.delete();
      prev_acc = 1'b0; prev_wr = 1'b0; m_locked = 1'b0;
    end else begin
      prev_acc = g0 | g1;
      prev_wr  = 1'b0;
      w = g1;
      if (g0 | g1) begin
        a   = w ? m1_if.address : m0_if.address;
        wwr = w ? m1_if.write : m0_if.write;
        if (wwr)
          shadow[a] = merge(shadow[a], w ? m1_if.writedata : m0_if.writedata,
                            w ? m1_if.byteenable : m0_if.byteenable);
        else
          pend.push_back('{due: cyc + 2, owner: w, data: shadow[a]});
        prev_wr = wwr;
        m_last  = w;
      end
`ifdef CORE8_MEM_ARB_LOCK_EN
      lk0 = m0_if.lock; lk1 = m1_if.lock;
      if (g0 | g1) begin
        if (w ? lk1 : lk0) begin
          m_locked = 1'b1; m_owner = w;
        end else if (m_locked && w == m_owner) begin
          m_locked = 1'b0;
        end
      end else if (m_locked && !(m_owner ? r1 : r0) && !(m_owner ? lk1 : lk0)) begin
        m_locked = 1'b0;
      end
`endif
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(input int n);
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      ram[i] = '0;
      shadow[i] = '0;
    end
    ram[13'h1FFF]    = 32'h12345678;
    shadow[13'h1FFF] = 32'h12345678;
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
`ifdef CORE8_MEM_ARB_LOCK_EN
    set_lock(0, 0);
`endif
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    step();
    step();
    reset_n = 1'b1;
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_be", 32'(mem_byteenable), 32'd0);
    chk("rst_wdata", mem_writedata, 32'd0);

    // write then read-after-write on m0
    drive(0, 0, 1, 13'h0010, 4'hF, 32'hDEADBEEF); step();
    drive(0, 1, 0, 13'h0010, 4'hF, 32'h0);        step();
    idle_steps(3);

    // fresh reset so master 0 wins the first tie, then 6 cycles of contention
    reset_n = 1'b0; step(); reset_n = 1'b1;
    drive(0, 1, 0, 13'h0010, 4'hF, 32'h0);
    drive(1, 1, 0, 13'h1FFF, 4'hF, 32'h0);
    for (int i = 0; i < 6; i++) step();
    idle_steps(3);

    // partial-byte write by m1 over a preloaded word, then read back
    drive(1, 0, 1, 13'h1FFF, 4'h3, 32'hAAAA5555); step();
    drive(1, 1, 0, 13'h1FFF, 4'hF, 32'h0);        step();
    idle_steps(3);

    // read in flight dropped by reset; first request after release accepted
    drive(0, 1, 0, 13'h0010, 4'hF, 32'h0); step();
    reset_n = 1'b0; step(); step();
    reset_n = 1'b1;
    drive(0, 1, 0, 13'h1FFF, 4'hF, 32'h0); step();
    idle_steps(3);

    // read and write together behave as a write
    drive(1, 1, 1, 13'h0004, 4'hF, 32'h0000CAFE); step();
    idle_steps(1);
    drive(0, 1, 0, 13'h0004, 4'hF, 32'h0); step();
    idle_steps(3);

`ifdef CORE8_MEM_ARB_LOCK_EN
    // locked read by m0 starves m1 until m0 releases with an unlocked write
    set_lock(1, 0);
    drive(0, 1, 0, 13'h0020, 4'hF, 32'h0); step();
    drive(0, 0, 0, 13'h0020, 4'hF, 32'h0);
    drive(1, 1, 0, 13'h0004, 4'hF, 32'h0);
    step(); step();
    set_lock(0, 0);
    drive(0, 0, 1, 13'h0020, 4'hF, 32'h600DF00D); step();
    drive(0, 0, 0, '0, '0, '0); step();
    idle_steps(3);
`endif

    // random traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      for (int n = 0; n < 2; n++) begin
        int op;
        op = int'($urandom_range(0, 3));
        drive(n, op[0], op[1], 13'($urandom_range(0, 15)), 4'($urandom_range(1, 15)),
              32'($urandom));
      end
`ifdef CORE8_MEM_ARB_LOCK_EN
      set_lock($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
`endif
      reset_n = ($urandom_range(0, 49) != 0);
      step();
    end
    reset_n = 1'b1;
`ifdef CORE8_MEM_ARB_LOCK_EN
    set_lock(0, 0);
`endif
    idle_steps(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
